dm_resp: RTL and testbench

Data-memory responder for the CPU's load/store port: the target side of the data bus that the core drives as initiator. It accepts one request at a time over a valid/ready handshake and models a configurable number of wait states. It performs byte/half/word reads with sign or zero extension and lane-masked writes, and flags misaligned or out-of-range accesses. It replaces the zero-wait combinational data memory in stall-capable pipeline configurations.

---
 rtl/dm_resp.sv | 202 ++++++++++++++++++++
 tb/tb_dm_resp.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_resp.sv
// Data-memory responder for the core's load/store port: one request at a time,
// LATENCY wait states, byte/half/word access with extension and error flagging.
module dm_resp #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    state_t      next_state;
    logic [3:0]  cnt;
    logic        accept;
    logic        commit;

    logic        cap_we;
    logic [31:0] cap_addr;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [31:0] cap_wdata;

    logic        eff_we;
    logic [31:0] eff_addr;
    logic [1:0]  eff_size;
    logic        eff_unsigned;
    logic [31:0] eff_wdata;

    logic          acc_err;
    logic [AW-1:0] word_idx;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_val;
    logic [31:0]   wr_data;
    logic [3:0]    wr_be;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept = req_valid && req_ready;
    assign commit = ((state == IDLE) && accept && (LATENCY == 0)) ||
                    ((state == WAIT) && (cnt == 4'd0));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_state = (LATENCY == 0) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd0) begin
                    next_state = RESP;
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state == IDLE);
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= 4'd0;
        end else if ((state == IDLE) && accept && (LATENCY != 0)) begin
            cnt <= 4'(LATENCY - 1);
        end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if ((state == IDLE) && accept) begin
            cap_we       <= req_we;
            cap_addr     <= req_addr;
            cap_size     <= req_size;
            cap_unsigned <= req_unsigned;
            cap_wdata    <= req_wdata;
        end
    end

    // With zero wait states the commit edge is the accept edge, so the live bus is used there.
    always_comb begin
        if (state == IDLE) begin
            eff_we       = req_we;
            eff_addr     = req_addr;
            eff_size     = req_size;
            eff_unsigned = req_unsigned;
            eff_wdata    = req_wdata;
        end else begin
            eff_we       = cap_we;
            eff_addr     = cap_addr;
            eff_size     = cap_size;
            eff_unsigned = cap_unsigned;
            eff_wdata    = cap_wdata;
        end
    end

    always_comb begin
        acc_err = 1'b0;
        if (eff_size == 2'd3) begin
            acc_err = 1'b1;
        end
        if ((eff_size == 2'd1) && eff_addr[0]) begin
            acc_err = 1'b1;
        end
        if ((eff_size == 2'd2) && (eff_addr[1:0] != 2'b00)) begin
            acc_err = 1'b1;
        end
        if ({2'b00, eff_addr[31:2]} >= 32'(DEPTH_WORDS)) begin
            acc_err = 1'b1;
        end
    end

    assign word_idx = eff_addr[AW+1:2];

    always_comb begin
        rd_word = mem[word_idx];
        case (eff_addr[1:0])
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
        rd_half = eff_addr[1] ? rd_word[31:16] : rd_word[15:0];
        case (eff_size)
            2'd0:    load_val = eff_unsigned ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'd1:    load_val = eff_unsigned ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_val = rd_word;
        endcase
    end

    // Store data is replicated across lanes; the byte enables pick which lanes land.
    always_comb begin
        case (eff_size)
            2'd0: begin
                wr_data = {4{eff_wdata[7:0]}};
                wr_be   = 4'b0001 << eff_addr[1:0];
            end
            2'd1: begin
                wr_data = {2{eff_wdata[15:0]}};
                wr_be   = eff_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                wr_data = eff_wdata;
                wr_be   = 4'b1111;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (commit && eff_we && !acc_err) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_be[i]) begin
                    mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_rdata <= (acc_err || eff_we) ? 32'd0 : load_val;
            rsp_err   <= acc_err;
        end
    end

endmodule

// File: tb/tb_dm_resp.sv
// Scoreboard bench for dm_resp: three responders (LATENCY 2, 0, 4) share one request
// bus; a byte-level reference model predicts every response and its arrival cycle.
module tb_dm_resp;

    localparam int DEPTH = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [2:0]  req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic [2:0]  rsp_valid;
    logic [31:0] rsp_rdata [3];
    logic [2:0]  rsp_err;

    typedef struct {
        int          inst;
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t       sbq[$];
    bit [7:0]   mdl [longint];
    int         cycle = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    dm_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut_lat2 (
        .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
    );

    dm_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut_lat0 (
        .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
    );

    dm_resp #(.DEPTH_WORDS(DEPTH), .LATENCY(4)) dut_lat4 (
        .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
        .req_we(req_we), .req_addr(req_addr), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid[2]), .rsp_rdata(rsp_rdata[2]), .rsp_err(rsp_err[2])
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int latOf(input int inst);
        return (inst == 0) ? 2 : ((inst == 1) ? 0 : 4);
    endfunction

    function automatic longint keyOf(input int inst, input logic [31:0] addr);
        return (longint'(inst) << 32) | longint'(addr);
    endfunction

    // Byte-addressed reference memory; loads assemble bytes little-endian and extend.
    function automatic void modelAccess(input int inst, input logic we, input logic [31:0] addr,
                                        input logic [1:0] size, input logic uns,
                                        input logic [31:0] wdata,
                                        output logic [31:0] rdata, output logic err);
        int          nb;
        logic [31:0] tmp;
        nb    = 1 << size;
        err   = (size == 2'd3) || ((addr % nb) != 0) || ((addr >> 2) >= DEPTH);
        rdata = 32'd0;
        if (err) return;
        if (we) begin
            for (int b = 0; b < nb; b++) begin
                tmp = wdata >> (8 * b);
                mdl[keyOf(inst, addr + b)] = tmp[7:0];
            end
        end else begin
            for (int b = 0; b < nb; b++) begin
                rdata = rdata | (32'(mdl[keyOf(inst, addr + b)]) << (8 * b));
            end
            if (!uns && nb < 4 && rdata[8*nb-1]) begin
                rdata = rdata | ~((32'd1 << (8 * nb)) - 32'd1);
            end
        end
    endfunction

    always @(negedge clk) begin : monitor
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (rsp_valid[i] === 1'b1) begin
                if (sbq.size() == 0) begin
                    checkOutput($sformatf("spurious_rsp_inst%0d", i), 32'(rsp_valid[i]), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    checkOutput("rsp_inst", i, e.inst);
                    checkOutput($sformatf("rsp_cycle_inst%0d", i), cycle, e.due);
                    checkOutput($sformatf("rsp_rdata_inst%0d", i), rsp_rdata[i], e.rdata);
                    checkOutput($sformatf("rsp_err_inst%0d", i), 32'(rsp_err[i]), 32'(e.err));
                end
            end
        end
    end

    task automatic scrambleBus();
        req_we       = 1'($urandom);
        req_addr     = $urandom;
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        req_wdata    = $urandom;
    endtask

    task automatic checkReset(input string tag);
        for (int i = 0; i < 3; i++) begin
            checkOutput($sformatf("%s_ready%0d", tag, i), 32'(req_ready[i]), 32'd1);
            checkOutput($sformatf("%s_valid%0d", tag, i), 32'(rsp_valid[i]), 32'd0);
            checkOutput($sformatf("%s_rdata%0d", tag, i), rsp_rdata[i], 32'd0);
            checkOutput($sformatf("%s_err%0d", tag, i), 32'(rsp_err[i]), 32'd0);
        end
    endtask

    task automatic waitDrain();
        for (int k = 0; k < 40 && sbq.size() != 0; k++) @(negedge clk);
        checkOutput("rsp_timeout", sbq.size(), 32'd0);
    endtask

    // One request; the bus is scrambled right after the accept edge.
    task automatic applyStimulus(input int inst, input logic we, input logic [31:0] addr,
                                 input logic [1:0] size, input logic uns, input logic [31:0] wdata);
        logic [31:0] erd;
        logic        eerr;
        bit          done;
        @(negedge clk);
        req_we       = we;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
        req_valid[inst] = 1'b1;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            if (req_ready[inst] === 1'b1) begin
                modelAccess(inst, we, addr, size, uns, wdata, erd, eerr);
                sbq.push_back('{inst, erd, eerr, cycle + 1 + latOf(inst)});
                @(posedge clk);
                #1;
                req_valid[inst] = 1'b0;
                scrambleBus();
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        if (!done) begin
            req_valid[inst] = 1'b0;
            checkOutput("accept_timeout", 32'(req_ready[inst]), 32'd1);
        end
        waitDrain();
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [31:0] erd;
        logic        eerr;

        rst          = 1'b0;
        req_valid    = 3'b000;
        req_we       = 1'b0;
        req_addr     = 32'd0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_wdata    = 32'd0;
        #2;
        checkReset("reset");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkReset("post_reset");

        $display("[TB] word store then load, LATENCY 2");
        applyStimulus(0, 1'b1, 32'h10, 2'd2, 1'b0, 32'hDEADBEEF);
        applyStimulus(0, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0);

        $display("[TB] byte and half lanes");
        applyStimulus(0, 1'b1, 32'h20, 2'd2, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 32'h21, 2'd0, 1'b0, 32'hFFFFFF80);
        applyStimulus(0, 1'b0, 32'h21, 2'd0, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 32'h21, 2'd0, 1'b1, 32'h0);
        applyStimulus(0, 1'b0, 32'h20, 2'd2, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 32'h22, 2'd1, 1'b0, 32'h0000A5B6);
        applyStimulus(0, 1'b0, 32'h22, 2'd1, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 32'h22, 2'd1, 1'b1, 32'h0);
        applyStimulus(0, 1'b0, 32'h20, 2'd2, 1'b1, 32'h0);

        $display("[TB] misalignment and range");
        applyStimulus(0, 1'b1, 32'h4, 2'd2, 1'b0, 32'h11223344);
        applyStimulus(0, 1'b0, 32'h3, 2'd1, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 32'h6, 2'd2, 1'b0, 32'hBADBAD00);
        applyStimulus(0, 1'b0, 32'(DEPTH * 4), 2'd2, 1'b0, 32'h0);
        applyStimulus(0, 1'b1, 32'h4, 2'd3, 1'b0, 32'hFFFFFFFF);
        applyStimulus(0, 1'b0, 32'h4, 2'd2, 1'b0, 32'h0);
        applyStimulus(0, 1'b0, 32'((DEPTH - 1) * 4), 2'd0, 1'b0, 32'h0);

        $display("[TB] LATENCY 0 back-to-back with valid held");
        applyStimulus(1, 1'b1, 32'h10, 2'd2, 1'b0, 32'h5A5A1234);
        @(negedge clk);
        req_we       = 1'b0;
        req_addr     = 32'h10;
        req_size     = 2'd2;
        req_unsigned = 1'b0;
        req_valid[1] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            checkOutput($sformatf("b2b_ready_%0d", k), 32'(req_ready[1]), 32'(k % 2 == 0));
            if (req_ready[1] === 1'b1) begin
                modelAccess(1, 1'b0, 32'h10, 2'd2, 1'b0, 32'h0, erd, eerr);
                sbq.push_back('{1, erd, eerr, cycle + 1});
            end
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        waitDrain();

        $display("[TB] reset during WAIT, LATENCY 4");
        applyStimulus(2, 1'b1, 32'h40, 2'd2, 1'b0, 32'hCAFEF00D);
        @(negedge clk);
        req_we       = 1'b1;
        req_addr     = 32'h40;
        req_size     = 2'd2;
        req_wdata    = 32'h12345678;
        req_valid[2] = 1'b1;
        @(posedge clk);
        #1;
        req_valid[2] = 1'b0;
        scrambleBus();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        checkReset("mid_wait_reset");
        @(negedge clk);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        applyStimulus(2, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0);

        $display("[TB] LATENCY 4 byte traffic with bus scrambled during WAIT");
        applyStimulus(2, 1'b1, 32'h43, 2'd0, 1'b0, 32'h0000007E);
        applyStimulus(2, 1'b0, 32'h40, 2'd2, 1'b0, 32'h0);
        applyStimulus(2, 1'b0, 32'h42, 2'd1, 1'b0, 32'h0);

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
